jtframe_objscan: RTL and testbench
==================================

Name: jtframe_objscan

Overview:
- Per-line object scanner; sits directly upstream of the 16x16 tile-line drawer (jtframe_draw).
- On each line start, walks object attribute RAM in ascending order and rejects objects not on the line.
- Issues one draw request per visible object over the drawer's draw/busy handshake.
- Reports line overflow and scan completion to the video timing logic.

Parameters:
- CW, 12: tile code width; must be 16 or less.
- PW, 8: pixel width; palette field is PW-4 bits.
- OBJW, 7: object index width (2^OBJW objects).
- LIMIT, 32: maximum draw requests per line.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- hs  in  1  line-start strobe; a rising edge starts a scan
- vrender  in  9  line being prepared
- ram_addr  out  OBJW+2  {object index, word[1:0]}
- ram_data  in  16  attribute word; valid one cycle after ram_addr
- draw  out  1  one-cycle request to drawer
- busy  in  1  drawer busy
- code  out  CW  tile code
- xpos  out  9  x position
- ysub  out  4  row inside tile
- hflip  out  1  horizontal flip
- vflip  out  1  vertical flip
- pal  out  PW-4  palette
- done  out  1  high from end of scan until next hs edge
- overflow  out  1  LIMIT reached this line; cleared on next hs edge

Behaviour:
- Attribute words per object:
  - w0: [15] disable, [8:0] y.
  - w1: [CW-1:0] code.
  - w2: [8:0] x.
  - w3: [15] hflip, [14] vflip, [PW-5:0] pal.
- Reset: all outputs 0, state IDLE, object index 0, request count 0. Reset mid-scan aborts immediately, with no further draw pulses.
- hs rising edge is detected internally using a registered hs. In any state it:
  - latches vrender;
  - sets object index and request count to 0;
  - clears done and overflow;
  - enters FETCH0.
- Every in-progress read or wait is abandoned on that edge, including a new line arriving mid-scan. An edge in the same cycle as draw lets the pulse complete, but no request follows.
- States:
  - IDLE: wait for the hs edge.
  - FETCH0: ram_addr={idx,0}, then go to CHK.
  - CHK: dy = vlatch - w0[8:0], modulo 512, 9-bit wrap. Visible iff !w0[15] and dy<16. If visible: ysub=dy[3:0], go to FETCH1. Otherwise go to NEXT.
  - FETCH1..3: fetch w1..w3, one word per cycle, capturing each word the cycle after its address. Go to WAIT.
  - WAIT: when busy==0 and no draw was pulsed in the previous cycle, assert draw for exactly one cycle, count+1, go to NEXT. The one-cycle guard covers the drawer raising busy one cycle after sampling draw.
  - NEXT: if idx is all ones, or count==LIMIT, go to DONE; otherwise idx+1 and go to FETCH0.
  - DONE: done=1 and hold until the next hs edge. If count==LIMIT and objects remain (idx not last), also set overflow=1.
- Cost per object: a rejected object takes 3 cycles (FETCH0, CHK, NEXT). A visible object takes at least 7 cycles.
- code, xpos, hflip, vflip, pal and ysub are stable from the draw cycle until the next FETCH1 capture.
- The drawer samples them only with draw.
- w0 y wrap: y=505 and vrender=3 gives dy=10, so the object is visible.
- The scanner never drives draw while busy is high.

Decomposition:
- Package jtframe_obj_pkg holds:
  - state enum (IDLE, FETCH0, CHK, FETCH1, FETCH2, FETCH3, WAIT, NEXT, DONE);
  - word index constants W_Y=0, W_CODE=1, W_X=2, W_ATTR=3;
  - bit positions DIS_BIT=15, HFLIP_BIT=15, VFLIP_BIT=14.
- Single module; no sub-module.
- Integration test pairs it with jtframe_draw and a line buffer model.

Test Plan:
- Reset and idle: rst_n low then high, no hs edge -> draw=0, done=0 and ram_addr=0 held for 100 cycles.
- Single visible object: obj0 has y=100, code=0x123, x=40, w3=0xC005; all others disabled; vrender=105, hs edge -> one draw pulse with code=0x123, xpos=40, ysub=5, hflip=1, vflip=1, pal=5. done rises after idx 127, overflow=0.
- Wrap and reject: obj3 y=505, obj4 y=90, vrender=3 -> only obj3 drawn, with ysub=10; obj4 gives no draw.
- Busy handshake: busy model held high for 20 cycles after each draw -> exactly one draw per visible object, never while busy=1, never in consecutive cycles.
- Overflow: 40 visible objects, LIMIT=32 -> 32 draw pulses, then done=1 and overflow=1. Next hs edge clears both.
- Mid-scan restart: second hs edge while in WAIT with busy=1 -> no stale draw; scan restarts at idx 0 with the new vrender. Async rst_n low during FETCH2 -> all outputs 0 immediately.

Source files
------------

// File: rtl/jtframe_obj_pkg.sv
// +--------------------------------------------------------------------------+
// | jtframe_obj_pkg : shared constants for the per-line object scanner        |
// | Revision 1.0 - initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package jtframe_obj_pkg;

    typedef logic [3:0] state_t;

    localparam state_t IDLE   = 4'd0;
    localparam state_t FETCH0 = 4'd1;
    localparam state_t CHK    = 4'd2;
    localparam state_t FETCH1 = 4'd3;
    localparam state_t FETCH2 = 4'd4;
    localparam state_t FETCH3 = 4'd5;
    localparam state_t WAIT   = 4'd6;
    localparam state_t NEXT   = 4'd7;
    localparam state_t DONE   = 4'd8;

    localparam logic [1:0] W_Y    = 2'd0;
    localparam logic [1:0] W_CODE = 2'd1;
    localparam logic [1:0] W_X    = 2'd2;
    localparam logic [1:0] W_ATTR = 2'd3;

    localparam int DIS_BIT   = 15;
    localparam int HFLIP_BIT = 15;
    localparam int VFLIP_BIT = 14;

endpackage

`default_nettype wire

// File: rtl/jtframe_objscan.sv
// +--------------------------------------------------------------------------+
// | jtframe_objscan : walks object RAM each line, issues one draw per object  |
// | Revision 1.0 - initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module jtframe_objscan
    import jtframe_obj_pkg::*;
#(
    parameter int CW    = 12,
    parameter int PW    = 8,
    parameter int OBJW  = 7,
    parameter int LIMIT = 32
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hs,
    input  logic [8:0]      vrender,
    output logic [OBJW+1:0] ram_addr,
    input  logic [15:0]     ram_data,
    output logic            draw,
    input  logic            busy,
    output logic [CW-1:0]   code,
    output logic [8:0]      xpos,
    output logic [3:0]      ysub,
    output logic            hflip,
    output logic            vflip,
    output logic [PW-5:0]   pal,
    output logic            done,
    output logic            overflow
);

    localparam int              CNTW    = $clog2(LIMIT + 1);
    localparam logic [CNTW-1:0] C_LIMIT = CNTW'(LIMIT);

    logic            r_hs;
    state_t          r_state;
    logic [OBJW-1:0] r_idx;
    logic [CNTW-1:0] r_cnt;
    logic [8:0]      r_vlatch;
    logic [3:0]      r_ysub;

    logic [1:0]      w_word;
    logic [8:0]      w_dy;
    logic            w_edge;
    logic            w_vis;
    logic            w_last;
    logic            w_full;
    logic            w_unused;

    assign w_edge   = hs & ~r_hs;
    assign w_dy     = r_vlatch - ram_data[8:0];
    assign w_vis    = ~ram_data[DIS_BIT] && (w_dy[8:4] == 5'd0);
    assign w_last   = &r_idx;
    assign w_full   = (r_cnt == C_LIMIT);
    assign w_unused = ^ram_data;

    // Address is combinational from state so the word is on the bus in the state that names it
    always_comb begin
        w_word = W_Y;
        case (r_state)
            FETCH1:       w_word = W_CODE;
            FETCH2:       w_word = W_X;
            FETCH3, WAIT: w_word = W_ATTR;
            default:      w_word = W_Y;
        endcase
    end

    assign ram_addr = {r_idx, w_word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs     <= 1'b0;
            r_state  <= IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_vlatch <= '0;
            r_ysub   <= '0;
            draw     <= 1'b0;
            code     <= '0;
            xpos     <= '0;
            ysub     <= '0;
            hflip    <= 1'b0;
            vflip    <= 1'b0;
            pal      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            r_hs <= hs;
            draw <= 1'b0;
            if (w_edge) begin
                r_vlatch <= vrender;
                r_idx    <= '0;
                r_cnt    <= '0;
                done     <= 1'b0;
                overflow <= 1'b0;
                r_state  <= FETCH0;
            end else begin
                case (r_state)
                    FETCH0: r_state <= CHK;
                    CHK: begin
                        r_ysub  <= w_dy[3:0];
                        r_state <= w_vis ? FETCH1 : NEXT;
                    end
                    FETCH1: r_state <= FETCH2;
                    // ysub moves with code so the drawer's inputs only change together
                    FETCH2: begin
                        code    <= ram_data[CW-1:0];
                        ysub    <= r_ysub;
                        r_state <= FETCH3;
                    end
                    FETCH3: begin
                        xpos    <= ram_data[8:0];
                        r_state <= WAIT;
                    end
                    WAIT: begin
                        hflip <= ram_data[HFLIP_BIT];
                        vflip <= ram_data[VFLIP_BIT];
                        pal   <= ram_data[PW-5:0];
                        if (!busy && !draw) begin
                            draw    <= 1'b1;
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= NEXT;
                        end
                    end
                    NEXT: begin
                        if (w_last || w_full) begin
                            done     <= 1'b1;
                            overflow <= w_full && !w_last;
                            r_state  <= DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= FETCH0;
                        end
                    end
                    IDLE, DONE: r_state <= r_state;
                    default:    r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jtframe_objscan.sv
// +--------------------------------------------------------------------------+
// | tb_jtframe_objscan : randomized bench with a per-line reference model     |
// | Revision 1.0 - initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_jtframe_objscan;

    localparam int CW    = 12;
    localparam int PW    = 8;
    localparam int OBJW  = 7;
    localparam int LIMIT = 32;
    localparam int NOBJ  = 1 << OBJW;

    typedef struct packed {
        logic [CW-1:0] code;
        logic [8:0]    x;
        logic [3:0]    ysub;
        logic          hf;
        logic          vf;
        logic [PW-5:0] pal;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            hs = 1'b0;
    logic [8:0]      vrender = '0;
    logic [OBJW+1:0] ram_addr;
    logic [15:0]     ram_data;
    logic            draw;
    logic            busy;
    logic [CW-1:0]   code;
    logic [8:0]      xpos;
    logic [3:0]      ysub;
    logic            hflip;
    logic            vflip;
    logic [PW-5:0]   pal;
    logic            done;
    logic            overflow;

    logic [15:0] mem [0:4*NOBJ-1];
    rec_t        obs_q[$];
    rec_t        exp_q[$];
    logic        exp_ovf = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          blen = 0;
    int          bcnt = 0;
    logic        force_busy = 1'b0;
    logic        prev_draw = 1'b0;

    jtframe_objscan #(.CW(CW), .PW(PW), .OBJW(OBJW), .LIMIT(LIMIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hs       (hs),
        .vrender  (vrender),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .draw     (draw),
        .busy     (busy),
        .code     (code),
        .xpos     (xpos),
        .ysub     (ysub),
        .hflip    (hflip),
        .vflip    (vflip),
        .pal      (pal),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_data <= mem[ram_addr];

    assign busy = force_busy | (bcnt > 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drawer stand-in: records requests and stays busy for blen cycles after each
    always @(negedge clk) begin
        if (draw) begin
            check("draw_vs_busy", busy, 0);
            check("draw_back2back", prev_draw, 0);
            obs_q.push_back({code, xpos, ysub, hflip, vflip, pal});
            bcnt = blen;
        end else if (bcnt > 0) begin
            bcnt--;
        end
        prev_draw = draw;
    end

    task automatic clear_mem();
        for (int i = 0; i < NOBJ; i++) begin
            mem[4*i]   = 16'h8000;
            mem[4*i+1] = 16'h0;
            mem[4*i+2] = 16'h0;
            mem[4*i+3] = 16'h0;
        end
    endtask

    task automatic set_obj(input int i, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
        mem[4*i]   = w0;
        mem[4*i+1] = w1;
        mem[4*i+2] = w2;
        mem[4*i+3] = w3;
    endtask

    task automatic build_model(input logic [8:0] v);
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i < NOBJ; i++) begin
            logic [15:0] w0;
            logic [15:0] w1;
            logic [15:0] w2;
            logic [15:0] w3;
            int          dy;
            w0 = mem[4*i];
            w1 = mem[4*i+1];
            w2 = mem[4*i+2];
            w3 = mem[4*i+3];
            dy = (int'(v) - int'(w0[8:0]) + 512) % 512;
            if (!w0[15] && dy < 16) begin
                exp_q.push_back({w1[CW-1:0], w2[8:0], 4'(dy), w3[15], w3[14], w3[PW-5:0]});
                if (exp_q.size() == LIMIT) begin
                    exp_ovf = (i != NOBJ - 1);
                    break;
                end
            end
        end
    endtask

    task automatic pulse_hs(input logic [8:0] v);
        @(negedge clk);
        vrender = v;
        hs = 1'b1;
        @(negedge clk);
        hs = 1'b0;
        check("done_cleared", done, 0);
        check("ovf_cleared", overflow, 0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic compare_line(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_rec"}, obs_q[i], exp_q[i]);
        check({tag, "_ovf"}, overflow, exp_ovf);
    endtask

    task automatic run_line(input logic [8:0] v, input string tag);
        obs_q.delete();
        build_model(v);
        pulse_hs(v);
        wait_done(tag);
        compare_line(tag);
    endtask

    task automatic random_mem(input logic [8:0] v, input int dens);
        for (int i = 0; i < NOBJ; i++) begin
            logic [15:0] w0;
            logic [8:0]  y;
            if (int'($urandom_range(0, 99)) < dens) begin
                y  = v - 9'($urandom_range(0, 15));
                w0 = {7'd0, y};
            end else begin
                w0 = 16'($urandom);
            end
            set_obj(i, w0, 16'($urandom), 16'($urandom), 16'($urandom));
        end
    endtask

    initial begin
        logic        bad;
        logic [8:0]  v;
        rec_t        r;

        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_outputs", {draw, done, overflow, code, xpos, ysub, hflip, vflip, pal}, 0);
        check("rst_addr", ram_addr, 0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (draw || done || ram_addr != 0) bad = 1'b1;
        end
        check("idle_quiet", bad, 0);

        // Single visible object
        clear_mem();
        set_obj(0, 16'd100, 16'h0123, 16'd40, 16'hC005);
        blen = 0;
        run_line(9'd105, "single");
        r = {12'h123, 9'd40, 4'd5, 1'b1, 1'b1, 4'd5};
        check("single_fields", (obs_q.size() == 1) ? 32'(obs_q[0]) : 32'hFFFF_FFFF, 32'(r));

        // Wrap-around visible, far object rejected
        clear_mem();
        set_obj(3, 16'd505, 16'h00AA, 16'd100, 16'h0003);
        set_obj(4, 16'd90,  16'h00BB, 16'd8,   16'h0000);
        run_line(9'd3, "wrap");
        check("wrap_ysub", (obs_q.size() == 1) ? 32'(obs_q[0].ysub) : 32'hFF, 10);
        check("wrap_code", (obs_q.size() == 1) ? 32'(obs_q[0].code) : 32'hFFFF, 12'h0AA);

        // Busy handshake with a long-busy drawer
        blen = 20;
        random_mem(9'd300, 20);
        run_line(9'd300, "busy20");

        // Overflow: 40 visible objects
        clear_mem();
        blen = 3;
        for (int i = 0; i < 40; i++)
            set_obj(i, 16'd200, 16'($urandom), 16'($urandom), 16'($urandom));
        run_line(9'd207, "ovf");
        check("ovf_32_draws", obs_q.size(), 32);
        check("ovf_flag", overflow, 1);

        // Random lines at several densities
        for (int k = 0; k < 9; k++) begin
            v = 9'($urandom);
            blen = $urandom_range(0, 20);
            random_mem(v, (k % 3 == 0) ? 5 : (k % 3 == 1) ? 30 : 70);
            run_line(v, "rand");
        end

        // Restart while stuck in WAIT
        clear_mem();
        set_obj(0,  16'd50,  16'h0111, 16'd10, 16'h0000);
        set_obj(10, 16'd200, 16'h0222, 16'd20, 16'h4002);
        blen = 0;
        force_busy = 1'b1;
        obs_q.delete();
        pulse_hs(9'd55);
        repeat (8) @(negedge clk);
        build_model(9'd210);
        pulse_hs(9'd210);
        force_busy = 1'b0;
        wait_done("restart");
        compare_line("restart");
        check("restart_code", (obs_q.size() > 0) ? 32'(obs_q[0].code) : 32'hFFFF, 12'h222);

        // Asynchronous reset while fetching word 2
        clear_mem();
        set_obj(0, 16'd100, 16'h00AB, 16'd77, 16'hC00F);
        run_line(9'd105, "pre_rst");
        pulse_hs(9'd105);
        repeat (3) @(posedge clk);
        #1;
        check("f2_addr", ram_addr, 2);
        check("f2_code_held", code, 12'h0AB);
        rst_n = 1'b0;
        #1;
        check("arst_outputs", {draw, done, overflow, code, xpos, ysub, hflip, vflip, pal}, 0);
        check("arst_addr", ram_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (draw || done) bad = 1'b1;
        end
        check("post_rst_quiet", bad, 0);

        blen = 5;
        random_mem(9'd128, 40);
        run_line(9'd128, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
